// File: rtl/csr_pkg.sv
// Shared CSR constants, cause codes and enums for the trap controller.
// Imported by csr_trap_controller and its sub-modules.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam int IRQ_M_TIMER = 7;
    localparam int IRQ_M_EXT   = 11;
    localparam int CAUSE_W     = 5;

    localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

    typedef enum logic [1:0] {
        MST_NONE   = 2'b00,
        MST_ENTER  = 2'b01,
        MST_RETURN = 2'b10
    } mstatus_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_ENTER,
        ST_REDIRECT,
        ST_RETURN
    } trap_state_e;

endpackage

// File: rtl/irq_sync.sv
// Flop-chain synchronizer for one asynchronous level interrupt.
// Ports: clk, reset (async active-low), irq (async in), synced (out).
module irq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic irq,
    output logic synced
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], irq};
        end
    end

    assign synced = chain[STAGES-1];

endmodule

// File: rtl/csr_trap_controller.sv
// Machine-mode interrupt entry / mret sequencer around the CSR unit.
// Ports: async irqs in, CSR state in, pipeline handshake, CSR trap write
// port (trap_we/mepc/mcause/mstatus_op) and fetch redirect out.
module csr_trap_controller
    import csr_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int SYNC_STAGES = 2,
    parameter int CAUSE_EXT   = IRQ_M_EXT,
    parameter int CAUSE_TIMER = IRQ_M_TIMER
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            irq_ext_i,
    input  logic            irq_timer_i,
    input  logic            csr_mstatus_mie_i,
    input  logic [XLEN-1:0] csr_mie_i,
    input  logic [XLEN-1:0] csr_mtvec_i,
    input  logic [XLEN-1:0] csr_mepc_i,
    input  logic            mret_i,
    input  logic [XLEN-1:0] pipe_pc_i,
    input  logic            pipe_idle_i,
    input  logic            redirect_ready_i,
    output logic [XLEN-1:0] mip_o,
    output logic            flush_req_o,
    output logic            trap_we_o,
    output logic [XLEN-1:0] mepc_o,
    output logic [XLEN-1:0] mcause_o,
    output logic [1:0]      mstatus_op_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            in_trap_o
);

    logic ext_s;
    logic tmr_s;

    irq_sync #(.STAGES(SYNC_STAGES)) u_sync_ext (
        .clk    (clk),
        .reset  (reset),
        .irq    (irq_ext_i),
        .synced (ext_s)
    );

    irq_sync #(.STAGES(SYNC_STAGES)) u_sync_tmr (
        .clk    (clk),
        .reset  (reset),
        .irq    (irq_timer_i),
        .synced (tmr_s)
    );

    always_comb begin
        mip_o              = '0;
        mip_o[CAUSE_EXT]   = ext_s;
        mip_o[CAUSE_TIMER] = tmr_s;
    end

    logic [XLEN-1:0]    armed;
    logic               pend;
    logic [CAUSE_W-1:0] cause_sel;

    assign armed     = mip_o & csr_mie_i;
    assign pend      = csr_mstatus_mie_i & (|armed);
    assign cause_sel = armed[CAUSE_EXT] ? CAUSE_W'(CAUSE_EXT)
                                        : CAUSE_W'(CAUSE_TIMER);

    trap_state_e        state_q;
    trap_state_e        state_d;
    logic [CAUSE_W-1:0] cause_q;
    logic [XLEN-1:0]    pc_q;
    logic               in_trap_q;
    logic               ret_first_q;
    // Blocks trap entry on the first IDLE cycle after mret so the
    // CSR unit's MIE restore is visible before pend is trusted.
    logic               hold_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cause_q     <= '0;
            pc_q        <= '0;
            in_trap_q   <= 1'b0;
            ret_first_q <= 1'b0;
            hold_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= (state_q == ST_RETURN) && redirect_ready_i;
            ret_first_q <= (state_q == ST_IDLE) && mret_i;
            // Cause tracks the highest-priority armed source until ENTER.
            if ((state_q == ST_IDLE || state_q == ST_DRAIN) && pend) begin
                cause_q <= cause_sel;
            end
            if (state_q == ST_DRAIN && pend && pipe_idle_i) begin
                pc_q <= pipe_pc_i;
            end
            if (state_q == ST_ENTER) begin
                in_trap_q <= 1'b1;
            end else if (state_q == ST_RETURN && redirect_ready_i) begin
                in_trap_q <= 1'b0;
            end
        end
    end

    logic [XLEN-1:0] tvec_base;
    logic [XLEN-1:0] tvec_off;

    assign tvec_base = csr_mtvec_i & ~XLEN'(3);
    assign tvec_off  = XLEN'({cause_q, 2'b00});

    always_comb begin
        state_d          = state_q;
        flush_req_o      = 1'b0;
        trap_we_o        = 1'b0;
        mepc_o           = '0;
        mcause_o         = '0;
        mstatus_op_o     = MST_NONE;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (mret_i) begin
                    state_d = ST_RETURN;
                end else if (pend && !hold_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                flush_req_o = 1'b1;
                if (!pend) begin
                    state_d = ST_IDLE;
                end else if (pipe_idle_i) begin
                    state_d = ST_ENTER;
                end
            end
            ST_ENTER: begin
                flush_req_o  = 1'b1;
                trap_we_o    = 1'b1;
                mstatus_op_o = MST_ENTER;
                mepc_o       = pc_q & ~XLEN'(3);
                mcause_o     = {1'b1, {(XLEN-1-CAUSE_W){1'b0}}, cause_q};
                state_d      = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                flush_req_o      = 1'b1;
                redirect_valid_o = 1'b1;
                if (csr_mtvec_i[1:0] == MTVEC_VECTORED) begin
                    redirect_pc_o = tvec_base + tvec_off;
                end else begin
                    redirect_pc_o = tvec_base;
                end
                if (redirect_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RETURN: begin
                redirect_valid_o = 1'b1;
                redirect_pc_o    = csr_mepc_i;
                if (ret_first_q) begin
                    mstatus_op_o = MST_RETURN;
                end
                if (redirect_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_trap_o = in_trap_q;

endmodule
